img_framer: RTL

IMG_FRAMER -- requirements
Module: img_framer

---
 rtl/img_framer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/img_framer.sv
// img_framer: emits header words, pixels, optional Fletcher-32 words and zero padding as a byte-swapped stream.
// Define IMG_FRAMER_CHECKSUM_EN to include the checksum logic and the CKSUM0/CKSUM1 words.
module img_framer #(
  parameter int unsigned HeaderWordCount = 8,
  parameter int unsigned AlignWords      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  input  logic        hdr_wr,
  input  logic [3:0]  hdr_idx,
  input  logic [15:0] hdr_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [15:0] pix_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_PIXELS, S_CKSUM0, S_CKSUM1, S_PAD
  } state_t;

  localparam logic [3:0] HdrLast = 4'(HeaderWordCount - 1);

  state_t      r_state;
  logic [15:0] r_hdr [16];
  logic [3:0]  r_hcnt;
  logic [31:0] r_npix;
  logic [31:0] r_pcnt;
  logic [31:0] r_cnt;
  logic        r_last;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_busy;
  logic        r_done;

  logic        w_adv;
  logic [15:0] w_hv;
  logic [31:0] w_cnt1;
  logic        w_aligned;
  state_t      w_tail_state;
  state_t      w_data_end;
  logic        w_data_end_last;

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  assign w_adv        = !r_out_valid || out_ready;
  assign w_hv         = r_hdr[r_hcnt];
  assign w_cnt1       = r_cnt + 32'd1;
  // Alignment is judged on the count including the word being loaded now.
  assign w_aligned    = (w_cnt1 % AlignWords) == 32'd0;
  assign w_tail_state = w_aligned ? S_IDLE : S_PAD;

`ifdef IMG_FRAMER_CHECKSUM_EN
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] w_fv;
  logic [16:0] w_as;
  logic [16:0] w_bs;
  logic [15:0] w_an;
  logic [15:0] w_bn;

  assign w_fv = (r_state == S_HEADER) ? w_hv : pix_data;
  assign w_as = {1'b0, r_a} + {1'b0, w_fv};
  assign w_an = (w_as >= 17'd65535) ? 16'(w_as - 17'd65535) : w_as[15:0];
  assign w_bs = {1'b0, r_b} + {1'b0, w_an};
  assign w_bn = (w_bs >= 17'd65535) ? 16'(w_bs - 17'd65535) : w_bs[15:0];

  assign w_data_end      = S_CKSUM0;
  assign w_data_end_last = 1'b0;
`else
  assign w_data_end      = w_tail_state;
  assign w_data_end_last = w_aligned;
`endif

  assign pix_ready = (r_state == S_PIXELS) && w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hcnt      <= '0;
      r_npix      <= '0;
      r_pcnt      <= '0;
      r_cnt       <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) r_hdr[i] <= '0;
`ifdef IMG_FRAMER_CHECKSUM_EN
      r_a <= '0;
      r_b <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (hdr_wr && !r_busy && (32'(hdr_idx) < HeaderWordCount)) r_hdr[hdr_idx] <= hdr_data;

      // Frame completes when the word flagged last leaves the output register.
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        if (r_last) begin
          r_last <= 1'b0;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start && !r_busy) begin
            r_busy  <= 1'b1;
            r_npix  <= {16'h0000, cfg_width} * {16'h0000, cfg_height};
            r_hcnt  <= '0;
            r_pcnt  <= '0;
            r_cnt   <= '0;
`ifdef IMG_FRAMER_CHECKSUM_EN
            r_a <= '0;
            r_b <= '0;
`endif
            r_state <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= swap16(w_hv);
            r_cnt       <= w_cnt1;
`ifdef IMG_FRAMER_CHECKSUM_EN
            r_a <= w_an;
            r_b <= w_bn;
`endif
            if (r_hcnt == HdrLast) begin
              if (r_npix == 32'd0) begin
                r_state <= w_data_end;
                r_last  <= w_data_end_last;
              end else begin
                r_state <= S_PIXELS;
              end
            end else begin
              r_hcnt <= r_hcnt + 4'd1;
            end
          end
        end
        S_PIXELS: begin
          if (w_adv && pix_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= swap16(pix_data);
            r_cnt       <= w_cnt1;
            r_pcnt      <= r_pcnt + 32'd1;
`ifdef IMG_FRAMER_CHECKSUM_EN
            r_a <= w_an;
            r_b <= w_bn;
`endif
            if (r_pcnt + 32'd1 == r_npix) begin
              r_state <= w_data_end;
              r_last  <= w_data_end_last;
            end
          end
        end
`ifdef IMG_FRAMER_CHECKSUM_EN
        S_CKSUM0: begin
          if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= swap16(r_a);
            r_cnt       <= w_cnt1;
            r_state     <= S_CKSUM1;
          end
        end
        S_CKSUM1: begin
          if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= swap16(r_b);
            r_cnt       <= w_cnt1;
            r_state     <= w_tail_state;
            r_last      <= w_aligned;
          end
        end
`endif
        S_PAD: begin
          if (w_adv) begin
            r_out_valid <= 1'b1;
            r_out_data  <= '0;
            r_cnt       <= w_cnt1;
            r_state     <= w_tail_state;
            r_last      <= w_aligned;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
